// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, defaults and helpers for the multi-port register file
// Holds the clear/run state enum, the MIPS default geometry and an address range check.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    localparam int RF_DEF_WIDTH = 32;
    localparam int RF_DEF_NREGS = 32;

    // True when addr names a real entry; NREGS need not be a power of two.
    function automatic logic addr_valid(input logic [31:0] addr, input int unsigned nregs);
        return addr < nregs;
    endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// rtl/regfile_clear_ctrl.sv - clear/run sequencer that initialises every register file entry
// Ports: clk, reset (sync, active-high), clr_req (re-clear request, honoured in RUN);
//        ready/run (file initialised), clr_we/clr_addr/clr_data (storage clear write).
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int               WIDTH   = RF_DEF_WIDTH,
    parameter int               NREGS   = RF_DEF_NREGS,
    parameter int               AW      = 5,
    parameter logic [WIDTH-1:0] INIT_R1 = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_req,
    output logic             ready,
    output logic             run,
    output logic             clr_we,
    output logic [AW-1:0]    clr_addr,
    output logic [WIDTH-1:0] clr_data
);

    rf_state_t     state, state_n;
    logic [AW-1:0] cnt, cnt_n;
    logic          ready_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RF_CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ready <= ready_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ready_n = ready;
        clr_we  = 1'b0;
        case (state)
            RF_CLEAR: begin
                // Reset must never touch storage, so the clear write waits for reset to drop.
                clr_we = !reset;
                cnt_n  = cnt + 1'b1;
                if (cnt == AW'(NREGS - 1)) begin
                    state_n = RF_RUN;
                    cnt_n   = '0;
                    ready_n = 1'b1;
                end
            end
            RF_RUN: begin
                if (clr_req) begin
                    state_n = RF_CLEAR;
                    cnt_n   = '0;
                    ready_n = 1'b0;
                end
            end
            default: begin
                state_n = RF_CLEAR;
                cnt_n   = '0;
                ready_n = 1'b0;
            end
        endcase
    end

    assign run      = (state == RF_RUN);
    assign clr_addr = cnt;
    assign clr_data = (cnt == AW'(1)) ? INIT_R1 : '0;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with bypass, zero register and clear engine
// Ports: clk, reset (sync, active-high), clr_req; rd_addr/rd_data (NRD packed combinational reads);
//        wr_en/wr_addr/wr_data (NWR packed writes, highest port wins); ready (initialised, accepting writes).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int               WIDTH    = RF_DEF_WIDTH,
    parameter int               NREGS    = RF_DEF_NREGS,
    parameter int               NRD      = 2,
    parameter int               NWR      = 1,
    parameter int               BYPASS   = 1,
    parameter int               ZERO_REG = 1,
    parameter logic [WIDTH-1:0] INIT_R1  = 1,
    localparam int              AW       = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr_req,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*WIDTH-1:0] wr_data,
    output logic                 ready
);

    logic [WIDTH-1:0] mem [NREGS];

    logic             run;
    logic             clr_we;
    logic [AW-1:0]    clr_addr;
    logic [WIDTH-1:0] clr_data;
    logic [NWR-1:0]   wr_ok;
    logic             wr_commit;

    regfile_clear_ctrl #(
        .WIDTH   (WIDTH),
        .NREGS   (NREGS),
        .AW      (AW),
        .INIT_R1 (INIT_R1)
    ) u_clear_ctrl (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .ready    (ready),
        .run      (run),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .clr_data (clr_data)
    );

    // Address names a real, writable/readable entry (entry 0 is hard-wired when ZERO_REG is set).
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return addr_valid(32'(a), NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Per-port write qualification, independent of reset/clr_req so bypass has no path from them.
    always_comb begin
        wr_ok = '0;
        for (int p = 0; p < NWR; p++) begin
            wr_ok[p] = run && wr_en[p] && addr_ok(wr_addr[p*AW +: AW]);
        end
    end

    // A re-clear or reset edge drops any write presented alongside it.
    assign wr_commit = !clr_req && !reset;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= clr_data;
        end else if (wr_commit) begin
            // Ascending loop: the last non-blocking update wins, giving highest-port priority.
            for (int p = 0; p < NWR; p++) begin
                if (wr_ok[p]) begin
                    mem[wr_addr[p*AW +: AW]] <= wr_data[p*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NRD; k++) begin
            if (run && addr_ok(rd_addr[k*AW +: AW])) begin
                rd_data[k*WIDTH +: WIDTH] = mem[rd_addr[k*AW +: AW]];
                if (BYPASS != 0) begin
                    for (int p = 0; p < NWR; p++) begin
                        if (wr_ok[p] && (wr_addr[p*AW +: AW] == rd_addr[k*AW +: AW])) begin
                            rd_data[k*WIDTH +: WIDTH] = wr_data[p*WIDTH +: WIDTH];
                        end
                    end
                end
            end
        end
    end

endmodule
